// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator.
//   state_t         : frame FSM states (IDLE / ACCUM / HOLD)
//   acc_max(w)      : largest signed value representable in w bits (64-bit result)
//   acc_min(w)      : smallest signed value representable in w bits, sign-extended to 64 bits
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [63:0] acc_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed saturating adder.
//   a, b  : ACC_W-bit two's-complement operands
//   sum   : a + b, clamped to the ACC_W signed range on overflow
//   clamp : 1 when the true sum did not fit and sum was clamped
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);

    localparam logic [ACC_W-1:0] MAXV = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MINV = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The extra top bit is the true sign; disagreement with the ACC_W sign bit means overflow.
        clamp = wide[ACC_W] ^ wide[ACC_W-1];
        if (clamp) begin
            sum = wide[ACC_W] ? MINV : MAXV;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates a frame of signed Booth products {prod_ac,prod_qr} into a saturating accumulator
// and emits one result per frame over a valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   prod_ac/prod_qr : upper/lower halves of the signed product
//   in_valid/in_last/in_ready : product beat handshake; in_last marks the final term
//   out_data        : saturated frame sum
//   out_count       : number of terms in the frame
//   out_sat         : a clamp occurred somewhere in the frame
//   out_forced      : frame was closed by reaching MAX_TERMS rather than in_last
//   out_valid/out_ready : result handshake
//
// state | meaning
// IDLE  | no frame open, no result pending
// ACCUM | frame open, at least one term accumulated
// HOLD  | result presented on out_*, waiting for out_ready
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter  int MCAND_W   = 8,
    parameter  int MPLR_W    = 8,
    parameter  int ACC_W     = 24,
    parameter  int MAX_TERMS = 16,
    localparam int PW        = MCAND_W + MPLR_W,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MCAND_W-1:0] prod_ac,
    input  logic [MPLR_W-1:0]  prod_qr,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_sat,
    output logic               out_forced,
    output logic               out_valid,
    input  logic               out_ready
);

    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              sat;

    logic [PW-1:0]     prod_raw;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum;
    logic              clamp;
    logic              accept;
    logic              first;
    logic              frame_end;
    logic [CNT_W-1:0]  cnt_nx;
    logic              sat_nx;

    assign prod_raw = {prod_ac, prod_qr};
    assign prod_ext = ACC_W'($signed(prod_raw));

    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign in_ready  = (state != HOLD) | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);

    // Any beat taken outside ACCUM starts a fresh frame; in HOLD, acc still carries the old frame.
    assign first     = (state != ACCUM);
    assign base      = first ? '0 : acc;
    assign cnt_nx    = first ? CNT_W'(1) : count + CNT_W'(1);
    assign frame_end = in_last | (cnt_nx == CNT_W'(MAX_TERMS));

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (base),
        .b     (prod_ext),
        .sum   (sum),
        .clamp (clamp)
    );

    assign sat_nx = first ? clamp : (sat | clamp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nx = frame_end ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nx = frame_end ? HOLD : ACCUM;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else if (accept) begin
            acc   <= sum;
            count <= cnt_nx;
            sat   <= sat_nx;
        end
    end

    // Result register only loads on a frame-ending beat, so it is stable while HOLD waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_count  <= '0;
            out_sat    <= 1'b0;
            out_forced <= 1'b0;
        end else if (accept && frame_end) begin
            out_data   <= sum;
            out_count  <= cnt_nx;
            out_sat    <= sat_nx;
            out_forced <= ~in_last;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  prod_ac;
    logic [7:0]  prod_qr;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_sat_a, out_forced_a, out_valid_a;
    logic [23:0] out_data_a;
    logic [4:0]  out_count_a;

    logic        in_ready_b, out_sat_b, out_forced_b, out_valid_b;
    logic [17:0] out_data_b;
    logic [4:0]  out_count_b;

    int vectors;
    int miscompares;

    booth_product_accumulator #(
        .MCAND_W(8), .MPLR_W(8), .ACC_W(24), .MAX_TERMS(16)
    ) dut_a (
        .clk(clk), .rst(rst), .prod_ac(prod_ac), .prod_qr(prod_qr),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_count(out_count_a), .out_sat(out_sat_a),
        .out_forced(out_forced_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    booth_product_accumulator #(
        .MCAND_W(8), .MPLR_W(8), .ACC_W(18), .MAX_TERMS(16)
    ) dut_b (
        .clk(clk), .rst(rst), .prod_ac(prod_ac), .prod_qr(prod_qr),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_count(out_count_b), .out_sat(out_sat_b),
        .out_forced(out_forced_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input logic [15:0] v, input logic last);
        int waited;
        waited   = 0;
        prod_ac  = v[15:8];
        prod_qr  = v[7:0];
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready_a && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready_a) begin
            vectors++; miscompares++;
            $display("FAIL send_beat_timeout in_ready=%b expected 1", in_ready_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL consume_drop out_valid=%b expected 0", out_valid_a);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if ({out_valid_a, out_sat_a, out_forced_a, in_ready_a} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_flags valid/sat/forced/in_ready=%b expected 0001",
                     {out_valid_a, out_sat_a, out_forced_a, in_ready_a});
        end
        vectors++;
        if (out_data_a !== 24'd0 || out_count_a !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_data data=%0d count=%0d expected 0 0", out_data_a, out_count_a);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        send_beat(16'h000C, 1'b1);
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 24'd12 || out_count_a !== 5'd1
            || out_sat_a !== 1'b0 || out_forced_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_beat valid=%b data=%0d count=%0d sat=%b forced=%b expected 1 12 1 0 0",
                     out_valid_a, out_data_a, out_count_a, out_sat_a, out_forced_a);
        end
        consume();
    endtask

    task automatic test_multi_beat();
        send_beat(16'h000C, 1'b0);
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_midframe out_valid=%b expected 0", out_valid_a);
        end
        send_beat(16'hFFDD, 1'b0);
        send_beat(16'h0064, 1'b1);
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 24'd77 || out_count_a !== 5'd3) begin
            miscompares++;
            $display("FAIL multi_beat valid=%b data=%0d count=%0d expected 1 77 3",
                     out_valid_a, out_data_a, out_count_a);
        end
        consume();
        // Negative result path
        send_beat(16'hFFDD, 1'b0);
        send_beat(16'hFFF6, 1'b1);
        vectors++;
        if (out_data_a !== 24'hFFFFD3 || out_data_b !== 18'h3FFD3 || out_count_a !== 5'd2) begin
            miscompares++;
            $display("FAIL negative_sum data_a=%h data_b=%h count=%0d expected FFFFD3 3FFD3 2",
                     out_data_a, out_data_b, out_count_a);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        send_beat(16'h0007, 1'b1);
        prod_ac  = 8'h00;
        prod_qr  = 8'h14;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid_a !== 1'b1 || out_data_a !== 24'd7 || out_count_a !== 5'd1
                || in_ready_a !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable cyc=%0d valid=%b data=%0d count=%0d in_ready=%b expected 1 7 1 0",
                         i, out_valid_a, out_data_a, out_count_a, in_ready_a);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release in_ready=%b expected 1", in_ready_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 24'd20 || out_count_a !== 5'd1) begin
            miscompares++;
            $display("FAIL back_to_back valid=%b data=%0d count=%0d expected 1 20 1",
                     out_valid_a, out_data_a, out_count_a);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_drop out_valid=%b expected 0", out_valid_a);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) send_beat(16'h4000, (i == 8));
        vectors++;
        if (out_data_b !== 18'd131071 || out_sat_b !== 1'b1 || out_count_b !== 5'd9) begin
            miscompares++;
            $display("FAIL sat_pos_18 data=%0d sat=%b count=%0d expected 131071 1 9",
                     out_data_b, out_sat_b, out_count_b);
        end
        vectors++;
        if (out_data_a !== 24'd147456 || out_sat_a !== 1'b0) begin
            miscompares++;
            $display("FAIL nosat_24 data=%0d sat=%b expected 147456 0", out_data_a, out_sat_a);
        end
        consume();
        for (int i = 0; i < 9; i++) send_beat(16'hC000, (i == 8));
        vectors++;
        if (out_data_b !== 18'h20000 || out_sat_b !== 1'b1 || out_count_b !== 5'd9) begin
            miscompares++;
            $display("FAIL sat_neg_18 data=%h sat=%b count=%0d expected 20000 1 9",
                     out_data_b, out_sat_b, out_count_b);
        end
        vectors++;
        if (out_data_a !== 24'hFDC000 || out_sat_a !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_24 data=%h sat=%b expected FDC000 0", out_data_a, out_sat_a);
        end
        consume();
        // Sticky flag must clear at the start of the next frame
        send_beat(16'h0001, 1'b1);
        vectors++;
        if (out_sat_b !== 1'b0 || out_data_b !== 18'd1) begin
            miscompares++;
            $display("FAIL sat_clear sat=%b data=%0d expected 0 1", out_sat_b, out_data_b);
        end
        consume();
    endtask

    task automatic test_forced_end();
        for (int i = 0; i < 16; i++) send_beat(16'h0001, 1'b0);
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 24'd16 || out_count_a !== 5'd16
            || out_forced_a !== 1'b1) begin
            miscompares++;
            $display("FAIL forced_end valid=%b data=%0d count=%0d forced=%b expected 1 16 16 1",
                     out_valid_a, out_data_a, out_count_a, out_forced_a);
        end
        consume();
        send_beat(16'h0001, 1'b0);
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL beat17_open out_valid=%b expected 0", out_valid_a);
        end
        send_beat(16'h0002, 1'b1);
        vectors++;
        if (out_data_a !== 24'd3 || out_count_a !== 5'd2 || out_forced_a !== 1'b0) begin
            miscompares++;
            $display("FAIL beat17_frame data=%0d count=%0d forced=%b expected 3 2 0",
                     out_data_a, out_count_a, out_forced_a);
        end
        consume();
    endtask

    task automatic test_mid_reset();
        send_beat(16'h0003, 1'b0);
        send_beat(16'h0004, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid_a !== 1'b0 || out_count_a !== 5'd0 || in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_reset valid=%b count=%0d in_ready=%b expected 0 0 1",
                     out_valid_a, out_count_a, in_ready_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(16'h0005, 1'b1);
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 24'd5 || out_count_a !== 5'd1) begin
            miscompares++;
            $display("FAIL after_reset valid=%b data=%0d count=%0d expected 1 5 1",
                     out_valid_a, out_data_a, out_count_a);
        end
        // Reset while a result is pending discards it immediately
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid_a !== 1'b0 || out_data_a !== 24'd0) begin
            miscompares++;
            $display("FAIL pending_reset valid=%b data=%0d expected 0 0", out_valid_a, out_data_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        prod_ac     = 8'h00;
        prod_qr     = 8'h00;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_saturation();
        test_forced_end();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
